// File: rtl/reg_bank8.sv
// Eight-entry 32-bit register bank: direct write port plus ROM bulk-load sequencer.
// Define REG_BANK8_ZERO_R0_EN to hardwire r0 to zero (ROM word for r0 is still fetched).
module reg_bank8 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned ROM_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  r0,
  output logic [WIDTH-1:0]  r1,
  output logic [WIDTH-1:0]  r2,
  output logic [WIDTH-1:0]  r3,
  output logic [WIDTH-1:0]  r4,
  output logic [WIDTH-1:0]  r5,
  output logic [WIDTH-1:0]  r6,
  output logic [WIDTH-1:0]  r7
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  localparam logic [ROM_AW-1:0] BaseAddr = ROM_AW'(ROM_BASE);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       pend_q;
  logic             pend_vld_q;
  logic [WIDTH-1:0] regs_q [8];

  logic             wr_en;
  logic [2:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;

  // Single write port: direct writes only in IDLE, ROM write-back while loading.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = waddr;
    wr_data = wdata;
    unique case (state_q)
      StIdle: wr_en = we;
      StLoad, StDrain: begin
        wr_en   = pend_vld_q;
        wr_idx  = pend_q;
        wr_data = rom_data;
      end
      default: ;
    endcase
`ifdef REG_BANK8_ZERO_R0_EN
    if (wr_idx == 3'd0) wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // rom_addr presents the index issued this cycle; pend_q tracks the one whose data is on rom_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      pend_q     <= 3'd0;
      pend_vld_q <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q    <= StLoad;
            idx_q      <= 3'd0;
            pend_vld_q <= 1'b0;
            rom_en     <= 1'b1;
            rom_addr   <= BaseAddr;
            busy       <= 1'b1;
          end
        end
        StLoad: begin
          pend_q     <= idx_q;
          pend_vld_q <= 1'b1;
          if (idx_q == 3'd7) begin
            state_q <= StDrain;
            rom_en  <= 1'b0;
          end else begin
            idx_q    <= idx_q + 3'd1;
            rom_addr <= BaseAddr + ROM_AW'(idx_q + 3'd1);
          end
        end
        StDrain: begin
          state_q    <= StDone;
          pend_vld_q <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r0 = regs_q[0];
  assign r1 = regs_q[1];
  assign r2 = regs_q[2];
  assign r3 = regs_q[3];
  assign r4 = regs_q[4];
  assign r5 = regs_q[5];
  assign r6 = regs_q[6];
  assign r7 = regs_q[7];

endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: two instances (ROM_BASE 0 and 0xFC) share stimulus.
module tb_reg_bank8;

`ifdef REG_BANK8_ZERO_R0_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_start, we;
  logic [2:0]  waddr;
  logic [31:0] wdata;

  logic        en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [31:0] ra [8];
  logic [31:0] rb [8];

  int n_cmp = 0;
  int n_bad = 0;

  // Synchronous ROM models: ROM[k] = 0x100 + k.
  always_ff @(posedge clk) if (en_a) data_a <= 32'h100 + 32'(addr_a);
  always_ff @(posedge clk) if (en_b) data_b <= 32'h100 + 32'(addr_b);

  reg_bank8 #(.WIDTH(32), .ROM_AW(8), .ROM_BASE(0)) dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .we(we), .waddr(waddr), .wdata(wdata),
    .rom_en(en_a), .rom_addr(addr_a), .rom_data(data_a), .busy(busy_a), .done(done_a),
    .r0(ra[0]), .r1(ra[1]), .r2(ra[2]), .r3(ra[3]),
    .r4(ra[4]), .r5(ra[5]), .r6(ra[6]), .r7(ra[7])
  );

  reg_bank8 #(.WIDTH(32), .ROM_AW(8), .ROM_BASE(252)) dut_b (
    .clk(clk), .rst(rst), .load_start(load_start), .we(we), .waddr(waddr), .wdata(wdata),
    .rom_en(en_b), .rom_addr(addr_b), .rom_data(data_b), .busy(busy_b), .done(done_b),
    .r0(rb[0]), .r1(rb[1]), .r2(rb[2]), .r3(rb[3]),
    .r4(rb[4]), .r5(rb[5]), .r6(rb[6]), .r7(rb[7])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input int base, input int i);
    if (i == 0 && Z) return 32'h0;
    return 32'h100 + 32'((base + i) % 256);
  endfunction

  // c counts cycles after the edge E0 that sampled load_start (c=1 is the cycle after E0).
  task automatic load_and_check(input bit inject, input string tag);
    int          dones;
    logic [31:0] prev0, prev7;
    dones = 0;
    prev0 = ra[0];
    prev7 = ra[7];
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("%s rom_en c%0d", tag, c), 32'(en_a), 32'(c <= 8));
      if (c <= 8) begin
        chk($sformatf("%s addr_a c%0d", tag, c), 32'(addr_a), 32'(c - 1));
        chk($sformatf("%s addr_b c%0d", tag, c), 32'(addr_b), 32'((251 + c) % 256));
      end
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy_a), 32'(c <= 9));
      chk($sformatf("%s done c%0d", tag, c), 32'(done_a), 32'(c == 10));
      if (c == 2)  chk($sformatf("%s r0 early", tag), ra[0], prev0);
      if (c == 3)  chk($sformatf("%s r0 at E2", tag), ra[0], exp_load(0, 0));
      if (c == 9)  chk($sformatf("%s r7 early", tag), ra[7], prev7);
      if (c == 10) chk($sformatf("%s r7 at E9", tag), ra[7], exp_load(0, 7));
      dones += int'(done_a);
      if (inject) begin
        we         = (c == 5 || c == 9 || c == 10);
        waddr      = (c == 5) ? 3'd2 : (c == 9) ? 3'd6 : 3'd4;
        wdata      = 32'h55;
        load_start = (c == 3 || c == 10);
      end
      @(negedge clk);
    end
    we = 1'b0;
    load_start = 1'b0;
    chk($sformatf("%s done count", tag), 32'(dones), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s a r%0d", tag, i), ra[i], exp_load(0, i));
      chk($sformatf("%s b r%0d", tag, i), rb[i], exp_load(252, i));
    end
  endtask

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{3'd5, 32'hDEADBEEF, 3'd5, 32'hDEADBEEF};
    vecs[1] = '{3'd0, 32'h00001234, 3'd0, (Z ? 32'h0 : 32'h00001234)};
    vecs[2] = '{3'd7, 32'hA5A5A5A5, 3'd7, 32'hA5A5A5A5};
    vecs[3] = '{3'd5, 32'h00000001, 3'd5, 32'h00000001};
    vecs[4] = '{3'd3, 32'hCAFEF00D, 3'd7, 32'hA5A5A5A5};
    vecs[5] = '{3'd1, 32'h0BADF00D, 3'd3, 32'hCAFEF00D};

    rst = 1'b1; load_start = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("reset a r%0d", i), ra[i], 32'h0);
      chk($sformatf("reset b r%0d", i), rb[i], 32'h0);
    end
    chk("reset rom_en", 32'(en_a), 32'h0);
    chk("reset rom_addr", 32'(addr_a), 32'h0);
    chk("reset busy", 32'(busy_a), 32'h0);
    chk("reset done", 32'(done_a), 32'h0);

    for (int v = 0; v < 6; v++) begin
      we = 1'b1; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      @(negedge clk);
      we = 1'b0;
      chk($sformatf("wr vec%0d a", v), ra[vecs[v].idx], vecs[v].exp);
      chk($sformatf("wr vec%0d b", v), rb[vecs[v].idx], vecs[v].exp);
    end
    chk("untouched r2", ra[2], 32'h0);
    chk("untouched r4", ra[4], 32'h0);
    chk("untouched r6", ra[6], 32'h0);

    load_and_check(1'b1, "load1");

    // Reset asserted during the 4th LOAD cycle.
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midload busy before rst", 32'(busy_a), 32'h1);
    chk("midload r1 reloaded", ra[1], 32'h101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("midrst a r%0d", i), ra[i], 32'h0);
      chk($sformatf("midrst b r%0d", i), rb[i], 32'h0);
    end
    chk("midrst rom_en", 32'(en_a), 32'h0);
    chk("midrst rom_addr", 32'(addr_a), 32'h0);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("midrst busy t%0d", c), 32'(busy_a), 32'h0);
      chk($sformatf("midrst done t%0d", c), 32'(done_a), 32'h0);
      @(negedge clk);
    end

    load_and_check(1'b0, "load2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
